// File: rtl/spi_arb_pkg.sv
// Shared state encoding and constants for the SPI master arbiter.
package spi_arb_pkg;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t IDLE  = 2'd0;
  localparam arb_state_t ISSUE = 2'd1;
  localparam arb_state_t BUSY  = 2'd2;
  localparam arb_state_t RESP  = 2'd3;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/spi_rr_pick.sv
// Rotate-priority search: first asserted req strictly after ptr, wrapping.
module spi_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IW      = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic               vld,
  output logic [IW-1:0]      idx
);

  int            c;
  logic [IW-1:0] ci;

  // Walk from farthest to nearest so the nearest hit is the one left standing.
  always_comb begin
    vld = 1'b0;
    idx = '0;
    c   = 0;
    ci  = '0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      c  = (int'(ptr) + i) % NUM_REQ;
      ci = IW'(c);
      if (req[ci]) begin
        vld = 1'b1;
        idx = ci;
      end
    end
  end

endmodule

// File: rtl/spi_mstr_arb.sv
// Round-robin arbiter sharing one 16-bit SPI master among NUM_REQ requesters.
// Optional BUSY watchdog enabled by defining SPI_ARB_TIMEOUT_EN.
//
// state | meaning
// IDLE  | no owner; grant first requester after rr_ptr
// ISSUE | wrt and req_ack pulse for the new owner
// BUSY  | waiting for a done rise (or watchdog expiry)
// RESP  | rsp_vld pulse; may re-grant immediately
module spi_mstr_arb
  import spi_arb_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 2048
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req,
  input  logic [16*NUM_REQ-1:0]   req_cmd,
  output logic [NUM_REQ-1:0]      req_ack,
  output logic [NUM_REQ-1:0]      rsp_vld,
  output logic [15:0]             rsp_data,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    wrt,
  output logic [15:0]             cmd,
  input  logic                    done,
  input  logic [15:0]             rd_data
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("spi_mstr_arb: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYC < 2 || TIMEOUT_CYC > 4096) begin : g_bad_timeout
    $error("spi_mstr_arb: TIMEOUT_CYC must fit the 12-bit watchdog");
  end

  arb_state_t         state;
  logic [IW-1:0]      rr_ptr;
  logic [IW-1:0]      pick_idx;
  logic               pick_vld;
  logic [NUM_REQ-1:0] pick_oh;
  logic [NUM_REQ-1:0] own_oh;
  logic               done_q;
  logic               done_rise;
  logic               tmo;
  logic               grant;

  spi_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IW      (IW)
  ) u_pick (
    .req (req),
    .ptr (rr_ptr),
    .vld (pick_vld),
    .idx (pick_idx)
  );

  assign pick_oh   = NUM_REQ'(1) << pick_idx;
  assign done_rise = done & ~done_q;
  // Granting from RESP as well as IDLE puts the next wrt 2 cycles after done rise.
  assign grant     = pick_vld & ((state == IDLE) | (state == RESP));

`ifdef SPI_ARB_TIMEOUT_EN
  logic [11:0] tmo_cnt;

  // Holds the number of cycles since wrt while in BUSY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt <= '0;
    end else if (state == ISSUE) begin
      tmo_cnt <= 12'd1;
    end else if (state == BUSY) begin
      tmo_cnt <= tmo_cnt + 12'd1;
    end
  end

  assign tmo = (state == BUSY) && (tmo_cnt == 12'(TIMEOUT_CYC - 1));
`else
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      rr_ptr   <= IW'(NUM_REQ - 1);
      own_oh   <= '0;
      done_q   <= 1'b0;
      wrt      <= 1'b0;
      cmd      <= '0;
      req_ack  <= '0;
      rsp_vld  <= '0;
      rsp_data <= '0;
      rsp_err  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      done_q  <= done;
      wrt     <= 1'b0;
      req_ack <= '0;
      rsp_vld <= '0;
      rsp_err <= 1'b0;
      if (grant) begin
        own_oh  <= pick_oh;
        rr_ptr  <= pick_idx;
        cmd     <= req_cmd[{pick_idx, 4'b0000} +: 16];
        wrt     <= 1'b1;
        req_ack <= pick_oh;
        busy    <= 1'b1;
        state   <= ISSUE;
      end else begin
        case (state)
          ISSUE: state <= BUSY;
          BUSY: begin
            if (done_rise) begin
              rsp_data <= rd_data;
              rsp_vld  <= own_oh;
              state    <= RESP;
            end else if (tmo) begin
              rsp_data <= TIMEOUT_DATA;
              rsp_err  <= 1'b1;
              rsp_vld  <= own_oh;
              state    <= RESP;
            end
          end
          RESP: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_mstr_arb.sv
// Directed bench for spi_mstr_arb: vector table plus hand-written corner sequences.
module tb_spi_mstr_arb;

  localparam int NR  = 3;
  localparam int TMO = 2048;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NR-1:0] req = '0;
  logic [47:0]   req_cmd = '0;
  logic [NR-1:0] req_ack;
  logic [NR-1:0] rsp_vld;
  logic [15:0]   rsp_data;
  logic          rsp_err;
  logic          busy;
  logic          wrt;
  logic [15:0]   cmd;
  logic          done = 1'b0;
  logic [15:0]   rd_data = '0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  spi_mstr_arb #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_cmd  (req_cmd),
    .req_ack  (req_ack),
    .rsp_vld  (rsp_vld),
    .rsp_data (rsp_data),
    .rsp_err  (rsp_err),
    .busy     (busy),
    .wrt      (wrt),
    .cmd      (cmd),
    .done     (done),
    .rd_data  (rd_data)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  typedef struct {
    logic [2:0]  req;
    logic [47:0] cmds;
    logic [2:0]  ack;
    logic [15:0] cmd;
    logic [15:0] rd;
  } vec_t;

  localparam logic [47:0] CMDS = {16'h3C02, 16'h2B01, 16'h1A00};

  vec_t       tv[9];
  logic [2:0] exp_ord[4];

  initial begin
    // rr_ptr starts at 2; each expected ack follows the rotation by hand.
    tv[0] = '{3'b010, {16'h3C02, 16'hA5C3, 16'h1A00}, 3'b010, 16'hA5C3, 16'h1234};
    tv[1] = '{3'b111, CMDS, 3'b100, 16'h3C02, 16'h0F0F};
    tv[2] = '{3'b011, CMDS, 3'b001, 16'h1A00, 16'hFFFF};
    tv[3] = '{3'b101, CMDS, 3'b100, 16'h3C02, 16'h0001};
    tv[4] = '{3'b011, CMDS, 3'b001, 16'h1A00, 16'h8000};
    tv[5] = '{3'b001, CMDS, 3'b001, 16'h1A00, 16'h5A5A};
    tv[6] = '{3'b110, CMDS, 3'b010, 16'h2B01, 16'h0000};
    tv[7] = '{3'b010, CMDS, 3'b010, 16'h2B01, 16'hC3C3};
    tv[8] = '{3'b101, CMDS, 3'b100, 16'h3C02, 16'h7E7E};
    exp_ord[0] = 3'b001;
    exp_ord[1] = 3'b010;
    exp_ord[2] = 3'b100;
    exp_ord[3] = 3'b001;

    step(); step();
    chk("rst_ctl", 32'({wrt, req_ack, rsp_vld, busy, rsp_err}), 32'd0);
    chk("rst_cmd", 32'(cmd), 32'd0);
    chk("rst_data", 32'(rsp_data), 32'd0);
    rst_n = 1'b1;
    step();

    for (int i = 0; i < 9; i++) begin
      req_cmd = tv[i].cmds;
      req     = tv[i].req;
      step();
      chk("vec_wrt", 32'(wrt), 32'd1);
      chk("vec_ack", 32'(req_ack), 32'(tv[i].ack));
      chk("vec_cmd", 32'(cmd), 32'(tv[i].cmd));
      chk("vec_busy", 32'(busy), 32'd1);
      req  = '0;
      done = 1'b0;
      repeat (2) begin
        step();
        chk("vec_no_early_vld", 32'(rsp_vld), 32'd0);
      end
      done    = 1'b1;
      rd_data = tv[i].rd;
      step();
      chk("vec_rsp_vld", 32'(rsp_vld), 32'(tv[i].ack));
      chk("vec_rsp_data", 32'(rsp_data), 32'(tv[i].rd));
      chk("vec_rsp_err", 32'(rsp_err), 32'd0);
      chk("vec_no_regrant", 32'(wrt), 32'd0);
      step();
      chk("vec_idle", 32'({busy, rsp_vld}), 32'd0);
    end

    // Stale done: done stays high from the previous transaction.
    req_cmd = CMDS;
    req     = 3'b001;
    step();
    chk("stale_ack", 32'(req_ack), 32'(3'b001));
    chk("stale_cmd", 32'(cmd), 32'h1A00);
    req = '0;
    repeat (5) begin
      step();
      chk("stale_no_vld", 32'(rsp_vld), 32'd0);
      chk("stale_busy", 32'(busy), 32'd1);
    end
    done = 1'b0;
    step();
    chk("stale_low_no_vld", 32'(rsp_vld), 32'd0);
    done    = 1'b1;
    rd_data = 16'hBEEF;
    step();
    chk("stale_rsp_vld", 32'(rsp_vld), 32'(3'b001));
    chk("stale_rsp_data", 32'(rsp_data), 32'hBEEF);
    step();
    chk("stale_idle", 32'(busy), 32'd0);

    // Reset while BUSY.
    req = 3'b010;
    step();
    chk("rb_ack", 32'(req_ack), 32'(3'b010));
    req  = '0;
    done = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("rb_ctl", 32'({wrt, req_ack, rsp_vld, busy, rsp_err}), 32'd0);
    chk("rb_cmd", 32'(cmd), 32'd0);
    chk("rb_data", 32'(rsp_data), 32'd0);
    step(); step();
    rst_n = 1'b1;
    repeat (3) begin
      step();
      chk("rb_no_vld", 32'(rsp_vld), 32'd0);
      chk("rb_not_busy", 32'(busy), 32'd0);
    end
    req = 3'b100;
    step();
    chk("rb_wrt", 32'(wrt), 32'd1);
    chk("rb_ack2", 32'(req_ack), 32'(3'b100));
    chk("rb_cmd2", 32'(cmd), 32'h3C02);
    req = '0;
    step(); step();
    done    = 1'b1;
    rd_data = 16'h1111;
    step();
    chk("rb_rsp_vld", 32'(rsp_vld), 32'(3'b100));
    chk("rb_rsp_data", 32'(rsp_data), 32'h1111);
    step();
    chk("rb_idle", 32'(busy), 32'd0);

    // Fresh reset, then full contention with back-to-back grants.
    rst_n = 1'b0;
    done  = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    req = 3'b111;
    step();
    for (int g = 0; g < 4; g++) begin
      chk((g == 0) ? "cont_wrt" : "b2b_wrt", 32'(wrt), 32'd1);
      chk("cont_ack", 32'(req_ack), 32'(exp_ord[g]));
      done = 1'b0;
      step(); step();
      done    = 1'b1;
      rd_data = 16'(16'h0100 + g);
      step();
      chk("cont_rsp_vld", 32'(rsp_vld), 32'(exp_ord[g]));
      chk("cont_rsp_data", 32'(rsp_data), 32'(16'h0100 + g));
      chk("cont_rsp_no_wrt", 32'(wrt), 32'd0);
      if (g == 3) req = '0;
      step();
      if (g == 3) chk("cont_idle", 32'({busy, wrt}), 32'd0);
    end

`ifdef SPI_ARB_TIMEOUT_EN
    begin
      int  k;
      bit  got;
      k   = 0;
      got = 1'b0;
      req = 3'b010;
      step();
      chk("tmo_ack", 32'(req_ack), 32'(3'b010));
      req  = '0;
      done = 1'b0;
      while (k < 3000 && !got) begin
        step();
        k++;
        if (rsp_vld != '0) got = 1'b1;
      end
      chk("tmo_seen", 32'(got), 32'd1);
      chk("tmo_cycles", 32'(k), 32'(TMO));
      chk("tmo_vld", 32'(rsp_vld), 32'(3'b010));
      chk("tmo_err", 32'(rsp_err), 32'd1);
      chk("tmo_data", 32'(rsp_data), 32'hDEAD);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish want finish before 2ms");
    $fatal(1, "simulation time limit reached");
  end

endmodule

// File: doc/spi_mstr_arb.md
Name: spi_mstr_arb

Overview:
Round-robin arbiter and sequencer that shares one 16-bit SPI master (wrt/cmd/done/rd_data handshake) between NUM_REQ requesters (e.g. inertial sensor poller, A2D poller, config writer). It grants one requester at a time and issues that requester's command as a single-cycle wrt pulse. It waits for the SPI transaction to complete, then returns rd_data to the owning requester with a one-cycle valid pulse.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYC, 2048, cycles allowed from wrt to done rise (optional feature only)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
req  input  NUM_REQ  per-requester request level; held high with stable cmd until its req_ack
req_cmd  input  16*NUM_REQ  per-requester command; slice i = [16*i+15:16*i]
req_ack  output  NUM_REQ  one-cycle pulse: command of requester i accepted
rsp_vld  output  NUM_REQ  one-cycle pulse: response for requester i valid on rsp_data
rsp_data  output  16  read data of last completed transaction
rsp_err  output  1  high with rsp_vld when transaction timed out (0 if feature absent)
busy  output  1  high from grant until response
wrt  output  1  to SPI master: start transaction, one-cycle pulse
cmd  output  16  to SPI master: command word, stable from wrt until done
done  input  1  from SPI master: level, rises at end of transaction, cleared by next wrt
rd_data  input  16  from SPI master: read data, valid when done rises

Behaviour:
- Clock clk; reset asynchronous active-low on rst_n. All outputs registered.
- Reset values: wrt=0, cmd=0, req_ack=0, rsp_vld=0, rsp_data=0, rsp_err=0, busy=0, state=IDLE, rr_ptr=NUM_REQ-1 (requester 0 wins first).
- done_q: flop of done; done_rise = done & ~done_q.
- IDLE: if |req, pick the first asserted requester searching from rr_ptr+1 upward, wrapping modulo NUM_REQ. Latch owner and cmd<=req_cmd[owner]; set rr_ptr<=owner and busy<=1; go ISSUE. Otherwise stay.
- ISSUE, one cycle: wrt=1, req_ack[owner]=1; go BUSY.
- BUSY: ignore req. On done_rise: rsp_data<=rd_data, rsp_vld[owner]=1 next cycle; go RESP. done already high on entry (level from previous transaction) is not a completion; only a rise after wrt counts.
- RESP, one cycle: rsp_vld pulse visible, busy<=0; go IDLE.
- Latency: req seen in cycle N gives wrt and req_ack in cycle N+1. done rise in cycle M gives rsp_vld in cycle M+1. Back-to-back grant occurs at the earliest 2 cycles after done rise.
- Fairness: a requester continuously asserting cannot win twice in a row while another is requesting.
- Requests arriving during ISSUE/BUSY/RESP are held by the requester, not queued internally.
- req deasserted before ack: in IDLE it is simply not considered. Dropping req after the grant cycle is illegal; that is requester protocol, not checked.
- Reset mid-transaction: immediate return to IDLE; no rsp_vld is issued for the aborted command. The SPI master shares rst_n.
- cmd holds its value after transaction (not cleared).

Optional Feature:
SPI_ARB_TIMEOUT_EN
- Defined: a 12-bit counter clears on ISSUE and increments in BUSY. Reaching TIMEOUT_CYC-1 without done_rise forces RESP with rsp_data=16'hDEAD, rsp_err=1.
- Undefined: no counter, BUSY waits indefinitely, rsp_err tied 0.

Decomposition:
- spi_arb_pkg: state enum {IDLE, ISSUE, BUSY, RESP} (2-bit) and constant TIMEOUT_DATA=16'hDEAD.
- One sub-module spi_rr_pick: combinational rotate-priority search (req vector, rr_ptr in; valid and index out), instantiated once.

Test Plan:
- Single request: req=3'b010, req_cmd[1]=16'hA5C3 -> wrt plus req_ack=3'b010 one cycle later, cmd=16'hA5C3. SPI model returns 16'h1234 -> rsp_vld=3'b010 with rsp_data=16'h1234 one cycle after done rise.
- Contention: req=3'b111 held after each ack -> grant order 0,1,2,0; no requester served twice consecutively.
- Stale done: done already high from prior transaction at ISSUE -> no rsp_vld until done falls and rises again.
- Reset in BUSY: assert rst_n=0 mid-transaction -> all outputs 0 immediately. After release, req=3'b100 is granted normally, starting from requester 0 priority.
- Back-to-back: two requesters pending -> second wrt exactly 2 cycles after first done rise.
- With SPI_ARB_TIMEOUT_EN, done never rises -> rsp_vld, rsp_err=1, rsp_data=16'hDEAD at TIMEOUT_CYC cycles after wrt.
